hex_display_driver: RTL

HEX_DISPLAY_DRIVER -- requirements
Module: hex_display_driver

---
 rtl/hex_display_driver.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/hex_display_driver.sv
// Six-digit seven-segment driver: score (BCD, zero-blanked), scrolling
// game-over message, or raw hex debug word, selected by a one-hot mode.
// All segment outputs are active-low {g,f,e,d,c,b,a} and registered.
module hex_display_driver #(
  parameter int unsigned SCROLL_TICKS = 12500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  displayMode,
  input  logic [13:0] score,
  input  logic [23:0] debugValue,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam int unsigned TICK_W = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCROLL_TICKS - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  typedef enum logic [2:0] {
    MODE_NORMAL   = 3'b001,
    MODE_GAMEOVER = 3'b010,
    MODE_DEBUG    = 3'b100
  } mode_e;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_LOAD,
    CV_SHIFT,
    CV_DONE
  } cv_state_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // "GAME OVEr" followed by three blanks, 12 slots
  function automatic logic [6:0] msg_glyph(input logic [3:0] slot);
    case (slot)
      4'd0: return 7'h42;
      4'd1: return 7'h08;
      4'd2: return 7'h48;
      4'd3: return 7'h06;
      4'd5: return 7'h40;
      4'd6: return 7'h41;
      4'd7: return 7'h06;
      4'd8: return 7'h2F;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] msg_at(input logic [3:0] base, input logic [2:0] off);
    logic [4:0] s;
    s = {1'b0, base} + {2'b00, off};
    if (s >= 5'd12) s = s - 5'd12;
    return msg_glyph(s[3:0]);
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // ---------------- score converter ----------------
  cv_state_e   cv_state;
  logic [13:0] clamped;
  logic [13:0] last_val;
  logic [13:0] bin_sr;
  logic [15:0] bcd_work;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_latched;
  logic [3:0]  shift_cnt;

  // Clamp the incoming score and pre-correct each BCD nibble before the shift
  always_comb begin
    clamped = (score > SCORE_MAX) ? SCORE_MAX : score;
    bcd_adj = {add3(bcd_work[15:12]), add3(bcd_work[11:8]),
               add3(bcd_work[7:4]),   add3(bcd_work[3:0])};
  end

  // Double-dabble sequencer; only DONE touches the displayed BCD
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cv_state    <= CV_IDLE;
      last_val    <= '0;
      bin_sr      <= '0;
      bcd_work    <= '0;
      bcd_latched <= '0;
      shift_cnt   <= '0;
    end else begin
      case (cv_state)
        CV_IDLE: begin
          if (clamped != last_val) cv_state <= CV_LOAD;
        end
        CV_LOAD: begin
          bin_sr    <= clamped;
          last_val  <= clamped;
          bcd_work  <= '0;
          shift_cnt <= '0;
          cv_state  <= CV_SHIFT;
        end
        CV_SHIFT: begin
          bcd_work  <= {bcd_adj[14:0], bin_sr[13]};
          bin_sr    <= {bin_sr[12:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == 4'd13) cv_state <= CV_DONE;
        end
        default: begin
          bcd_latched <= bcd_work;
          cv_state    <= CV_IDLE;
        end
      endcase
    end
  end

  // ---------------- game-over scroller ----------------
  logic              in_gameover;
  logic              prev_gameover;
  logic [3:0]        idx;
  logic [3:0]        idx_nxt;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] tick_nxt;

  // Next scroll position; the window is drawn from idx_nxt so each
  // position is visible for exactly SCROLL_TICKS output cycles
  always_comb begin
    in_gameover = (displayMode == MODE_GAMEOVER);
    idx_nxt     = idx;
    tick_nxt    = tick;
    if (!in_gameover || !prev_gameover) begin
      idx_nxt  = '0;
      tick_nxt = '0;
    end else if (tick == TICK_LAST) begin
      tick_nxt = '0;
      idx_nxt  = (idx == 4'd11) ? '0 : idx + 4'd1;
    end else begin
      tick_nxt = tick + TICK_W'(1);
    end
  end

  // Scroll position and entry detection registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_gameover <= 1'b0;
      idx           <= '0;
      tick          <= '0;
    end else begin
      prev_gameover <= in_gameover;
      idx           <= idx_nxt;
      tick          <= tick_nxt;
    end
  end

  // ---------------- output registers ----------------
  logic [3:0] d3, d2, d1, d0;
  logic       blank3, blank2, blank1;

  // Leading-zero blanking; units digit is never blanked
  always_comb begin
    {d3, d2, d1, d0} = bcd_latched;
    blank3 = (d3 == 4'd0);
    blank2 = blank3 && (d2 == 4'd0);
    blank1 = blank2 && (d1 == 4'd0);
  end

  // Mode mux into the registered segment outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {hex5, hex4, hex3, hex2, hex1, hex0} <= {6{SEG_BLANK}};
    end else begin
      case (displayMode)
        MODE_NORMAL: begin
          hex5 <= SEG_BLANK;
          hex4 <= SEG_BLANK;
          hex3 <= blank3 ? SEG_BLANK : hex_glyph(d3);
          hex2 <= blank2 ? SEG_BLANK : hex_glyph(d2);
          hex1 <= blank1 ? SEG_BLANK : hex_glyph(d1);
          hex0 <= hex_glyph(d0);
        end
        MODE_GAMEOVER: begin
          hex5 <= msg_at(idx_nxt, 3'd0);
          hex4 <= msg_at(idx_nxt, 3'd1);
          hex3 <= msg_at(idx_nxt, 3'd2);
          hex2 <= msg_at(idx_nxt, 3'd3);
          hex1 <= msg_at(idx_nxt, 3'd4);
          hex0 <= msg_at(idx_nxt, 3'd5);
        end
        MODE_DEBUG: begin
          hex5 <= hex_glyph(debugValue[23:20]);
          hex4 <= hex_glyph(debugValue[19:16]);
          hex3 <= hex_glyph(debugValue[15:12]);
          hex2 <= hex_glyph(debugValue[11:8]);
          hex1 <= hex_glyph(debugValue[7:4]);
          hex0 <= hex_glyph(debugValue[3:0]);
        end
        default: begin
          {hex5, hex4, hex3, hex2, hex1, hex0} <= {6{SEG_BLANK}};
        end
      endcase
    end
  end

endmodule
